bus_slave: RTL and testbench

BUS_SLAVE -- requirements
Module: bus_slave

---
 rtl/bus_if.sv | 20 ++
 rtl/bus_slave.sv | 74 +++++++
 tb/tb_bus_slave.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bus_if.sv
// Valid/ready word bus between an upstream master and the receive buffer.
interface bus_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/bus_slave.sv
// Receive-side bus slave: accepts words over a valid/ready bus into a small
// FIFO, presents the oldest word downstream, and counts accepted transfers.
module bus_slave #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  bus_if.slave                     bus,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              rx_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  // Ready comes only from stored occupancy and flush so a master can never
  // loop valid back into ready; reset_n gating holds it low while in reset.
  always_comb begin
    full      = (level == LW'(DEPTH));
    bus.ready = reset_n && !full && !flush;
    push      = bus.valid && bus.ready;
    out_valid = (level != '0);
    pop       = out_valid && out_ready && !flush;
    out_data  = mem[rd_ptr];
  end

  // Pointers, occupancy and transfer counter; flush wins over push/pop but
  // never touches the counter (push is already blocked while flushing).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        rx_count <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Word storage has no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data;
    end
  end

endmodule

// File: tb/tb_bus_slave.sv
// Self-checking bench for bus_slave: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_bus_slave;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [2:0]       level;
  logic [15:0]      rx_count;

  bus_if #(.WIDTH(WIDTH)) bus_vif ();

  bus_slave #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_vif),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .rx_count  (rx_count)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 0;

  logic [31:0] q[$];
  logic [15:0] m_rx;
  logic [15:0] saved_rx;

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: FIFO as a queue; a full buffer refuses the word even if it pops
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_rx <= 16'd0;
    end else if (flush) begin
      q.delete();
    end else if (q.size() == DEPTH) begin
      if (out_ready) void'(q.pop_front());
    end else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (bus_vif.valid) begin
        q.push_back(bus_vif.data);
        m_rx <= m_rx + 16'd1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", 32'(level), 32'(q.size()));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("bus_ready", 32'(bus_vif.ready),
            32'(reset_n && q.size() != DEPTH && !flush));
      check("rx_count", 32'(rx_count), 32'(m_rx));
      if (q.size() != 0) check("out_data", out_data, q[0]);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] d,
                                input logic ordy, input logic fl);
    #1;
    bus_vif.valid = v;
    bus_vif.data  = d;
    out_ready     = ordy;
    flush         = fl;
    @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [31:0] lvl,
                              input logic [31:0] vld, input logic [31:0] rdy,
                              input logic [31:0] rx);
    check({name, "_level"}, 32'(level), lvl);
    check({name, "_out_valid"}, 32'(out_valid), vld);
    check({name, "_ready"}, 32'(bus_vif.ready), rdy);
    check({name, "_rx"}, 32'(rx_count), rx);
  endtask

  initial begin
    reset_n       = 0;
    flush         = 0;
    out_ready     = 0;
    bus_vif.valid = 0;
    bus_vif.data  = '0;
    repeat (3) @(negedge clk);
    check_output("in_reset", 0, 0, 0, 0);
    #2 reset_n = 1;
    @(negedge clk);
    cmp_en = 1;
    check_output("post_reset", 0, 0, 1, 0);

    // Fill to full with 1,2,3,4; word 5 must be held off
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1, (i > 5) ? 32'd5 : 32'(i), 0, 0);
      if (i == 4) check_output("fill4", 4, 1, 0, 4);
    end
    check_output("full_hold", 4, 1, 0, 4);
    check("full_head", out_data, 32'd1);

    // Drain while master keeps offering; ready returns one cycle after first pop
    apply_stimulus(1, 5, 1, 0);
    check("pop1_data", out_data, 32'd2);
    check_output("pop1", 3, 1, 1, 4);
    apply_stimulus(1, 5, 1, 0);
    check("pop2_data", out_data, 32'd3);
    apply_stimulus(1, 6, 1, 0);
    check("pop3_data", out_data, 32'd4);
    repeat (4) apply_stimulus(0, 0, 1, 0);
    check_output("drained", 0, 0, 1, 6);

    // Streaming from empty: level settles at one, data passes in order
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 32'h100 + 32'(i), 1, 0);
      check("stream_level", 32'(level), 32'd1);
      check("stream_data", out_data, 32'h100 + 32'(i));
    end
    apply_stimulus(0, 0, 1, 0);

    // Flush with two words buffered and valid asserted
    apply_stimulus(1, 32'hA1, 0, 0);
    apply_stimulus(1, 32'hA2, 0, 0);
    check("preflush_level", 32'(level), 32'd2);
    saved_rx = m_rx;
    #1;
    bus_vif.valid = 1;
    bus_vif.data  = 32'hA3;
    flush         = 1;
    #1;
    check("flush_ready_comb", 32'(bus_vif.ready), 32'd0);
    @(negedge clk);
    check_output("flushed", 0, 0, 0, 32'(saved_rx));
    apply_stimulus(0, 0, 0, 0);
    check("after_flush_ready", 32'(bus_vif.ready), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 15) == 0);
    end
    repeat (DEPTH + 1) apply_stimulus(0, 0, 1, 0);

    // Stream until the counter sits two short of wrap, then cross it
    for (int i = 0; i < 70000 && m_rx != 16'hFFFE; i++) begin
      apply_stimulus(1, 32'(i), 1, 0);
    end
    check("rx_preload", 32'(rx_count), 32'hFFFE);
    apply_stimulus(1, 32'h11, 1, 0);
    check("rx_ffff", 32'(rx_count), 32'hFFFF);
    apply_stimulus(1, 32'h12, 1, 0);
    check("rx_0000", 32'(rx_count), 32'h0000);
    apply_stimulus(1, 32'h13, 1, 0);
    check("rx_0001", 32'(rx_count), 32'h0001);
    repeat (2) apply_stimulus(0, 0, 1, 0);

    // Asynchronous reset between edges with three words held
    for (int i = 0; i < 3; i++) apply_stimulus(1, 32'hC0 + 32'(i), 0, 0);
    check("preasync_level", 32'(level), 32'd3);
    #3 reset_n = 0;
    #1;
    check_output("async_reset", 0, 0, 0, 0);
    bus_vif.valid = 0;
    @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    repeat (2) apply_stimulus(0, 0, 1, 0);
    check_output("after_async", 0, 0, 1, 0);
    apply_stimulus(1, 32'hABCD, 0, 0);
    check_output("first_word", 1, 1, 1, 1);
    check("first_word_data", out_data, 32'hABCD);

    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
